// File: rtl/wb_port_sched.sv
// wb_port_sched: arbitrates E/M writeback and an optional debug writer onto one register-file write port.
// Debug port and its anti-starvation counter are built only with WB_SCHED_DBG_PORT_EN defined.
module wb_port_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  dstE,
    input  logic [63:0] valE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valM,
    input  logic        dbg_req,
    input  logic [3:0]  dbg_addr,
    input  logic [63:0] dbg_data,
    output logic        dbg_gnt,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        busy
);
`ifdef WB_SCHED_DBG_PORT_EN
    typedef enum logic [1:0] {IDLE, WR_E, WR_M, DBG} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  e_addr_q, e_addr_d, m_addr_q, m_addr_d;
    logic [63:0] e_data_q, e_data_d, m_data_q, m_data_d;
    logic        rf_we_q, rf_we_d;
    logic [3:0]  rf_waddr_q, rf_waddr_d;
    logic [63:0] rf_wdata_q, rf_wdata_d;
`ifdef WB_SCHED_DBG_PORT_EN
    logic [3:0]  g_addr_q, g_addr_d;
    logic [63:0] g_data_q, g_data_d;
    logic [2:0]  starve_q, starve_d;
    logic        dbg_gnt_q, dbg_gnt_d;

    assign wb_ready = rst_n && state_q == IDLE && !(dbg_req && starve_q == 3'd4);
    assign dbg_gnt  = dbg_gnt_q;
`else
    logic unused_dbg;

    assign wb_ready   = rst_n && state_q == IDLE;
    assign dbg_gnt    = 1'b0;
    assign unused_dbg = ^{dbg_req, dbg_addr, dbg_data};
`endif
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = state_q != IDLE;

    always_comb begin
        state_d  = state_q;
        e_addr_d = e_addr_q;
        e_data_d = e_data_q;
        m_addr_d = m_addr_q;
        m_data_d = m_data_q;
`ifdef WB_SCHED_DBG_PORT_EN
        g_addr_d = g_addr_q;
        g_data_d = g_data_q;
        starve_d = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (wb_valid && wb_ready) begin
                    e_addr_d = dstE;
                    e_data_d = valE;
                    m_addr_d = dstM;
                    m_data_d = valM;
                    // E is skipped when it targets the same register as M, so M wins
                    state_d  = (dstE != 4'hF && dstE != dstM) ? WR_E : (dstM != 4'hF) ? WR_M : IDLE;
`ifdef WB_SCHED_DBG_PORT_EN
                    if (dbg_req && starve_q != 3'd4)
                        starve_d = starve_q + 3'd1;
                end else if (dbg_req) begin
                    g_addr_d = dbg_addr;
                    g_data_d = dbg_data;
                    starve_d = '0;
                    state_d  = DBG;
`endif
                end
            end
            WR_E:    state_d = (m_addr_q != 4'hF) ? WR_M : IDLE;
            default: state_d = IDLE;
        endcase
`ifdef WB_SCHED_DBG_PORT_EN
        dbg_gnt_d  = state_d == DBG;
        rf_we_d    = state_d == WR_E || state_d == WR_M || (state_d == DBG && g_addr_d != 4'hF);
        rf_waddr_d = (state_d == WR_E) ? e_addr_d : (state_d == WR_M) ? m_addr_d :
                     (state_d == DBG) ? g_addr_d : 4'hF;
        rf_wdata_d = (state_d == WR_E) ? e_data_d : (state_d == WR_M) ? m_data_d :
                     (state_d == DBG) ? g_data_d : 64'd0;
`else
        rf_we_d    = state_d == WR_E || state_d == WR_M;
        rf_waddr_d = (state_d == WR_E) ? e_addr_d : (state_d == WR_M) ? m_addr_d : 4'hF;
        rf_wdata_d = (state_d == WR_E) ? e_data_d : (state_d == WR_M) ? m_data_d : 64'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            e_addr_q   <= '0;
            e_data_q   <= '0;
            m_addr_q   <= '0;
            m_data_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 4'hF;
            rf_wdata_q <= '0;
`ifdef WB_SCHED_DBG_PORT_EN
            g_addr_q   <= '0;
            g_data_q   <= '0;
            starve_q   <= '0;
            dbg_gnt_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            e_addr_q   <= e_addr_d;
            e_data_q   <= e_data_d;
            m_addr_q   <= m_addr_d;
            m_data_q   <= m_data_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
`ifdef WB_SCHED_DBG_PORT_EN
            g_addr_q   <= g_addr_d;
            g_data_q   <= g_data_d;
            starve_q   <= starve_d;
            dbg_gnt_q  <= dbg_gnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_port_sched.sv
// tb_wb_port_sched: directed and random checks of wb_port_sched against a queue-of-writes model.
module tb_wb_port_sched;
`ifdef WB_SCHED_DBG_PORT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_valid = 1'b0, wb_ready;
    logic [3:0]  dstE = 4'hF, dstM = 4'hF;
    logic [63:0] valE = '0, valM = '0;
    logic        dbg_req = 1'b0, dbg_gnt;
    logic [3:0]  dbg_addr = '0;
    logic [63:0] dbg_data = '0;
    logic        rf_we, busy;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;

    wb_port_sched dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Each queued entry is one cycle of port activity still owed by the scheduler
    typedef struct packed {logic we; logic [3:0] a; logic [63:0] d; logic g;} wr_t;
    wr_t q[$];
    int  starve = 0;
    bit  acc = 0, gnt = 0;
    int  n_assert = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return rst_n && q.size() == 0 && !(DBG_EN && dbg_req && starve == 4);
    endfunction

    task automatic check_outputs();
        wr_t h;
        h = '{we: 1'b0, a: 4'hF, d: 64'd0, g: 1'b0};
        if (q.size() != 0) h = q[0];
        chk("rf_we", rf_we, h.we);
        chk("rf_waddr", rf_waddr, h.a);
        chk("rf_wdata", rf_wdata, h.d);
        chk("dbg_gnt", dbg_gnt, h.g);
        chk("busy", busy, q.size() != 0);
        chk("wb_ready", wb_ready, exp_ready());
    endtask

    task automatic update_model();
        acc = 0;
        gnt = 0;
        if (!rst_n) begin
            q.delete();
            starve = 0;
        end else if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (wb_valid && exp_ready()) begin
            acc = 1;
            if (dstE != 4'hF && dstE != dstM) q.push_back('{we: 1'b1, a: dstE, d: valE, g: 1'b0});
            if (dstM != 4'hF) q.push_back('{we: 1'b1, a: dstM, d: valM, g: 1'b0});
            if (DBG_EN && dbg_req && starve < 4) starve++;
        end else if (DBG_EN && dbg_req) begin
            gnt = 1;
            q.push_back('{we: dbg_addr != 4'hF, a: dbg_addr, d: dbg_data, g: 1'b1});
            starve = 0;
        end
    endtask

    task automatic step();
        #1 check_outputs();
        update_model();
        @(negedge clk);
    endtask

    task automatic set_wb(input logic v, input logic [3:0] e, input logic [63:0] ve,
                          input logic [3:0] m, input logic [63:0] vm);
        wb_valid = v; dstE = e; valE = ve; dstM = m; valM = vm;
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        q.delete();
        starve = 0;
        acc = 0;
        gnt = 0;
        #1 check_outputs();
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 5));
    endfunction

    initial begin
        rst_n = 1'b0;
        #1 check_outputs();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        // single E write, then idle with ready back
        set_wb(1, 4'd2, 64'h11, 4'hF, 0); step();
        wb_valid = 0; step(); step(); step();
        // popq: E then M on consecutive cycles, followed by a held request
        set_wb(1, 4'd4, 64'h100, 4'd3, 64'hAB); step();
        set_wb(1, 4'd5, 64'h77, 4'hF, 0); step(); step(); step();
        wb_valid = 0; step(); step();
        // same destination: only the M value is written
        set_wb(1, 4'd4, 64'h100, 4'd4, 64'h55); step();
        wb_valid = 0; step(); step();
        // no destination at all, then M only
        set_wb(1, 4'hF, 64'h1, 4'hF, 64'h2); step();
        set_wb(1, 4'hF, 64'h3, 4'd7, 64'h99); step();
        wb_valid = 0; step(); step();
        // debug request against continuous writeback traffic
        dbg_req = 1; dbg_addr = 4'd9; dbg_data = 64'hDEAD_BEEF;
        set_wb(1, 4'd1, 64'h10, 4'hF, 0);
        for (int i = 0; i < 16; i++) begin
            if (gnt) dbg_req = 0;
            if (acc) set_wb(1, 4'd1, 64'h10 + 64'(i), 4'hF, 0);
            step();
        end
        wb_valid = 0; dbg_req = 1; dbg_addr = 4'hF; dbg_data = 64'h5A;
        step();
        for (int i = 0; i < 3; i++) begin
            if (gnt) dbg_req = 0;
            step();
        end
        dbg_req = 0;
        // reset during WR_E of a two-write request
        set_wb(1, 4'd4, 64'h100, 4'd3, 64'hAB); step();
        wb_valid = 0;
        mid_reset();
        step(); step(); step();
        // random traffic, requesters hold until served
        for (int i = 0; i < 800; i++) begin
            if (!(wb_valid && !acc))
                set_wb($urandom_range(0, 3) != 0, rnd_reg(), {$urandom, $urandom}, rnd_reg(), {$urandom, $urandom});
            if (!(DBG_EN && dbg_req && !gnt)) begin
                dbg_req  = $urandom_range(0, 3) == 0;
                dbg_addr = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
                dbg_data = {$urandom, $urandom};
            end
            if ($urandom_range(0, 99) == 0) mid_reset();
            else step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
